// File: rtl/wisc_pipe_pkg.sv
// Shared definitions for the WISC pipeline control logic: control FSM
// state encoding and the default HALT drain length.
package wisc_pipe_pkg;

  // Control FSM states; encoding 3 is unused and recovers to StRun.
  typedef enum logic [1:0] {
    StRun    = 2'd0,
    StDrain  = 2'd1,
    StHalted = 2'd2
  } ctrl_state_e;

  // Cycles spent draining EX/MEM and MEM/WB after HALT reaches EX.
  localparam int unsigned DrainCyclesDflt = 2;

  // Width of the drain counter; enough for drain lengths up to 7.
  localparam int unsigned DrainCntW = 3;

endpackage

// File: rtl/hazard_ld_use.sv
// Combinational load-use comparator: the instruction in EX is a load whose
// destination is a source register of the instruction in ID.
module hazard_ld_use (
  input  logic [2:0] id_rs,
  input  logic [2:0] id_rt,
  input  logic       id_rs_used,
  input  logic       id_rt_used,
  input  logic [2:0] ex_write_sel,
  input  logic       ex_mem_read,
  input  logic       ex_valid_rd,
  output logic       load_use
);

  logic w_rs_match;
  logic w_rt_match;

  assign w_rs_match = id_rs_used && (id_rs == ex_write_sel);
  assign w_rt_match = id_rt_used && (id_rt == ex_write_sel);
  assign load_use   = ex_mem_read && ex_valid_rd && (w_rs_match || w_rt_match);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard control for the 5-stage WISC CPU: freeze, flush and
// bubble commands for load-use, taken branches and data-memory stalls,
// plus the HALT drain state machine.
// Optional performance counters are built when HAZ_PERF_EN is defined.
module pipe_hazard_ctrl
  import wisc_pipe_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = DrainCyclesDflt,
  parameter int unsigned CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       id_rs,
  input  logic [2:0]       id_rt,
  input  logic             id_rs_used,
  input  logic             id_rt_used,
  input  logic [2:0]       ex_write_sel,
  input  logic             ex_Mem_read,
  input  logic             ex_valid_rd,
  input  logic             ex_branch_taken,
  input  logic             ex_halt,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_bubble,
  output logic             exmem_hold,
  output logic             halt_done,
`ifdef HAZ_PERF_EN
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
`endif
  output logic [1:0]       ctrl_state
);

  localparam logic [DrainCntW-1:0] DrainInit = DrainCntW'(DRAIN_CYCLES - 1);

  ctrl_state_e          r_state;
  ctrl_state_e          w_state_nxt;
  logic [DrainCntW-1:0] r_cnt;
  logic [DrainCntW-1:0] w_cnt_nxt;
  logic                 w_load_use;

  hazard_ld_use u_ld_use (
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_rs_used   (id_rs_used),
    .id_rt_used   (id_rt_used),
    .ex_write_sel (ex_write_sel),
    .ex_mem_read  (ex_Mem_read),
    .ex_valid_rd  (ex_valid_rd),
    .load_use     (w_load_use)
  );

  assign ctrl_state = r_state;

  // Mealy command outputs and next-state/counter decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_hold   = 1'b0;
    idex_bubble = 1'b0;
    exmem_hold  = 1'b0;
    halt_done   = 1'b0;
    if (!rst) begin
      case (r_state)
        StRun: begin
          if (mem_busy) begin
            // EX is frozen, so branch/halt/load-use re-evaluate after the stall.
            pc_hold    = 1'b1;
            ifid_hold  = 1'b1;
            idex_hold  = 1'b1;
            exmem_hold = 1'b1;
          end else if (ex_halt) begin
            pc_hold     = 1'b1;
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
            w_state_nxt = StDrain;
            w_cnt_nxt   = DrainInit;
          end else if (ex_branch_taken) begin
            // The ID instruction is squashed, so any load-use on it is moot.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (w_load_use) begin
            pc_hold     = 1'b1;
            ifid_hold   = 1'b1;
            idex_bubble = 1'b1;
          end
        end
        StDrain: begin
          pc_hold     = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          if (mem_busy) begin
            exmem_hold = 1'b1;
            idex_hold  = 1'b1;
          end else if (r_cnt != '0) begin
            w_cnt_nxt = r_cnt - 1'b1;
          end else begin
            w_state_nxt = StHalted;
          end
        end
        StHalted: begin
          pc_hold     = 1'b1;
          ifid_flush  = 1'b1;
          idex_bubble = 1'b1;
          halt_done   = 1'b1;
        end
        default: begin
          w_state_nxt = StRun;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State and drain counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StRun;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

`ifdef HAZ_PERF_EN
  localparam logic [CNT_W-1:0] PerfOne = CNT_W'(1);

  logic [CNT_W-1:0] r_perf_stall;
  logic [CNT_W-1:0] r_perf_flush;

  assign perf_stall_cnt = r_perf_stall;
  assign perf_flush_cnt = r_perf_flush;

  // Saturating counts of stall and flush cycles spent in RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_perf_stall <= '0;
      r_perf_flush <= '0;
    end else begin
      if ((r_state == StRun) && pc_hold && !(&r_perf_stall)) begin
        r_perf_stall <= r_perf_stall + PerfOne;
      end
      if ((r_state == StRun) && ifid_flush && !(&r_perf_flush)) begin
        r_perf_flush <= r_perf_flush + PerfOne;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (default DRAIN_CYCLES=2).
// Output vector order: {pc_hold, ifid_hold, ifid_flush, idex_hold,
// idex_bubble, exmem_hold, halt_done}.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic [2:0] id_rs;
  logic [2:0] id_rt;
  logic       id_rs_used;
  logic       id_rt_used;
  logic [2:0] ex_write_sel;
  logic       ex_Mem_read;
  logic       ex_valid_rd;
  logic       ex_branch_taken;
  logic       ex_halt;
  logic       mem_busy;
  logic       pc_hold;
  logic       ifid_hold;
  logic       ifid_flush;
  logic       idex_hold;
  logic       idex_bubble;
  logic       exmem_hold;
  logic       halt_done;
  logic [1:0] ctrl_state;
`ifdef HAZ_PERF_EN
  logic [15:0] perf_stall_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  logic [6:0] outs;
  int checks = 0;
  int errors = 0;

  assign outs = {pc_hold, ifid_hold, ifid_flush, idex_hold, idex_bubble, exmem_hold, halt_done};

  pipe_hazard_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs           (id_rs),
    .id_rt           (id_rt),
    .id_rs_used      (id_rs_used),
    .id_rt_used      (id_rt_used),
    .ex_write_sel    (ex_write_sel),
    .ex_Mem_read     (ex_Mem_read),
    .ex_valid_rd     (ex_valid_rd),
    .ex_branch_taken (ex_branch_taken),
    .ex_halt         (ex_halt),
    .mem_busy        (mem_busy),
    .pc_hold         (pc_hold),
    .ifid_hold       (ifid_hold),
    .ifid_flush      (ifid_flush),
    .idex_hold       (idex_hold),
    .idex_bubble     (idex_bubble),
    .exmem_hold      (exmem_hold),
    .halt_done       (halt_done),
`ifdef HAZ_PERF_EN
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_flush_cnt  (perf_flush_cnt),
`endif
    .ctrl_state      (ctrl_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    id_rs           = 3'd0;
    id_rt           = 3'd0;
    id_rs_used      = 1'b0;
    id_rt_used      = 1'b0;
    ex_write_sel    = 3'd0;
    ex_Mem_read     = 1'b0;
    ex_valid_rd     = 1'b0;
    ex_branch_taken = 1'b0;
    ex_halt         = 1'b0;
    mem_busy        = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    ex_halt  = 1'b1;
    mem_busy = 1'b1;
    #1;
    checks++;
    if (outs !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_outs got %b want %b", outs, 7'b0000000);
    end
    tick();
    rst = 1'b0;
    clear_inputs();
    #1;
    checks++;
    if (ctrl_state !== 2'd0) begin
      errors++;
      $display("FAIL reset_state got %0d want 0", ctrl_state);
    end
    checks++;
    if (outs !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_idle_outs got %b want %b", outs, 7'b0000000);
    end
  endtask

  task automatic test_load_use();
    ex_Mem_read  = 1'b1;
    ex_valid_rd  = 1'b1;
    ex_write_sel = 3'd3;
    id_rs        = 3'd3;
    id_rs_used   = 1'b1;
    #1;
    checks++;
    if (outs !== 7'b1100100) begin
      errors++;
      $display("FAIL load_use_rs got %b want %b", outs, 7'b1100100);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (outs !== 7'b0000000) begin
      errors++;
      $display("FAIL load_use_after got %b want %b", outs, 7'b0000000);
    end
    // Match through Rt only.
    ex_Mem_read  = 1'b1;
    ex_valid_rd  = 1'b1;
    ex_write_sel = 3'd5;
    id_rs        = 3'd2;
    id_rs_used   = 1'b1;
    id_rt        = 3'd5;
    id_rt_used   = 1'b1;
    #1;
    checks++;
    if (outs !== 7'b1100100) begin
      errors++;
      $display("FAIL load_use_rt got %b want %b", outs, 7'b1100100);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_no_stall();
    ex_Mem_read  = 1'b1;
    ex_valid_rd  = 1'b1;
    ex_write_sel = 3'd3;
    id_rs        = 3'd3;
    id_rt        = 3'd3;
    #1;
    checks++;
    if (outs !== 7'b0000000) begin
      errors++;
      $display("FAIL no_use got %b want %b", outs, 7'b0000000);
    end
    tick();
    id_rs_used  = 1'b1;
    id_rt_used  = 1'b1;
    ex_valid_rd = 1'b0;
    #1;
    checks++;
    if (outs !== 7'b0000000) begin
      errors++;
      $display("FAIL no_valid_rd got %b want %b", outs, 7'b0000000);
    end
    tick();
    ex_valid_rd = 1'b1;
    ex_Mem_read = 1'b0;
    #1;
    checks++;
    if (outs !== 7'b0000000) begin
      errors++;
      $display("FAIL not_load got %b want %b", outs, 7'b0000000);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_branch_load();
    ex_Mem_read     = 1'b1;
    ex_valid_rd     = 1'b1;
    ex_write_sel    = 3'd3;
    id_rs           = 3'd3;
    id_rs_used      = 1'b1;
    ex_branch_taken = 1'b1;
    #1;
    checks++;
    if (outs !== 7'b0010100) begin
      errors++;
      $display("FAIL branch_load got %b want %b", outs, 7'b0010100);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_mem_busy();
    ex_branch_taken = 1'b1;
    mem_busy        = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (outs !== 7'b1101010) begin
        errors++;
        $display("FAIL mem_busy_cyc%0d got %b want %b", i, outs, 7'b1101010);
      end
      tick();
    end
    mem_busy = 1'b0;
    #1;
    checks++;
    if (outs !== 7'b0010100) begin
      errors++;
      $display("FAIL mem_busy_release got %b want %b", outs, 7'b0010100);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_halt();
    logic [1:0] exp_state [3];
    logic [6:0] exp_outs [3];
    exp_state[0] = 2'd1; exp_outs[0] = 7'b1010100;
    exp_state[1] = 2'd1; exp_outs[1] = 7'b1010100;
    exp_state[2] = 2'd2; exp_outs[2] = 7'b1010101;
    ex_halt = 1'b1;
    #1;
    checks++;
    if (outs !== 7'b1010100 || ctrl_state !== 2'd0) begin
      errors++;
      $display("FAIL halt_issue got %b st %0d want %b st 0", outs, ctrl_state, 7'b1010100);
    end
    tick();
    ex_halt = 1'b0;
    // Branch and load-use must be ignored while draining.
    ex_branch_taken = 1'b1;
    ex_Mem_read     = 1'b1;
    ex_valid_rd     = 1'b1;
    id_rs_used      = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (ctrl_state !== exp_state[i] || outs !== exp_outs[i]) begin
        errors++;
        $display("FAIL halt_seq%0d got st %0d %b want st %0d %b", i, ctrl_state, outs,
                 exp_state[i], exp_outs[i]);
      end
      tick();
    end
    #1;
    checks++;
    if (ctrl_state !== 2'd2 || halt_done !== 1'b1) begin
      errors++;
      $display("FAIL halt_sticky got st %0d done %b want st 2 done 1", ctrl_state, halt_done);
    end
    clear_inputs();
  endtask

  task automatic test_halt_busy();
    logic [1:0] exp_state [4];
    logic [6:0] exp_outs [4];
    logic       busy [4];
    exp_state[0] = 2'd1; exp_outs[0] = 7'b1011110; busy[0] = 1'b1;
    exp_state[1] = 2'd1; exp_outs[1] = 7'b1010100; busy[1] = 1'b0;
    exp_state[2] = 2'd1; exp_outs[2] = 7'b1010100; busy[2] = 1'b0;
    exp_state[3] = 2'd2; exp_outs[3] = 7'b1010101; busy[3] = 1'b0;
    do_reset();
    ex_halt = 1'b1;
    tick();
    ex_halt = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mem_busy = busy[i];
      #1;
      checks++;
      if (ctrl_state !== exp_state[i] || outs !== exp_outs[i]) begin
        errors++;
        $display("FAIL halt_busy%0d got st %0d %b want st %0d %b", i, ctrl_state, outs,
                 exp_state[i], exp_outs[i]);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_drain();
    do_reset();
    ex_halt = 1'b1;
    tick();
    ex_halt = 1'b0;
    #1;
    checks++;
    if (ctrl_state !== 2'd1) begin
      errors++;
      $display("FAIL rd_enter got %0d want 1", ctrl_state);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (outs !== 7'b0000000) begin
      errors++;
      $display("FAIL rd_in_reset got %b want %b", outs, 7'b0000000);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (ctrl_state !== 2'd0 || outs !== 7'b0000000) begin
      errors++;
      $display("FAIL rd_after got st %0d %b want st 0 %b", ctrl_state, outs, 7'b0000000);
    end
    // A fresh HALT must take the full drain length again.
    ex_halt = 1'b1;
    tick();
    ex_halt = 1'b0;
    tick();
    #1;
    checks++;
    if (ctrl_state !== 2'd1 || halt_done !== 1'b0) begin
      errors++;
      $display("FAIL rd_redrain got st %0d done %b want st 1 done 0", ctrl_state, halt_done);
    end
    tick();
    #1;
    checks++;
    if (ctrl_state !== 2'd2 || halt_done !== 1'b1) begin
      errors++;
      $display("FAIL rd_rehalt got st %0d done %b want st 2 done 1", ctrl_state, halt_done);
    end
    clear_inputs();
  endtask

`ifdef HAZ_PERF_EN
  task automatic test_perf();
    do_reset();
    ex_branch_taken = 1'b1;
    repeat (3) tick();
    ex_branch_taken = 1'b0;
    #1;
    checks++;
    if (perf_flush_cnt !== 16'd3 || perf_stall_cnt !== 16'd0) begin
      errors++;
      $display("FAIL perf_flush got f %0d s %0d want f 3 s 0", perf_flush_cnt, perf_stall_cnt);
    end
    mem_busy = 1'b1;
    repeat (70000) @(posedge clk);
    #1;
    mem_busy = 1'b0;
    checks++;
    if (perf_stall_cnt !== 16'hFFFF || perf_flush_cnt !== 16'd3) begin
      errors++;
      $display("FAIL perf_sat got s %h f %0d want s ffff f 3", perf_stall_cnt, perf_flush_cnt);
    end
    do_reset();
    #1;
    checks++;
    if (perf_stall_cnt !== 16'd0 || perf_flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL perf_clear got s %0d f %0d want 0 0", perf_stall_cnt, perf_flush_cnt);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_load_use();
    test_no_stall();
    test_branch_load();
    test_mem_busy();
    test_halt();
    test_halt_busy();
    test_reset_drain();
`ifdef HAZ_PERF_EN
    test_perf();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
